// File: rtl/wb_stage_reg.sv
// M/W pipeline register with load alignment/extension and GRF write-value selection.
// Optional retirement counter (output retire_cnt) is enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] m_alu_out,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [DATA_W-1:0] m_pc8,
    input  logic [DATA_W-1:0] m_aux,
    input  logic [1:0]        m_sel,
    input  logic [2:0]        m_ld_type,
    input  logic              m_reg_we,
    input  logic [REG_AW-1:0] m_reg_addr,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_result,
    output logic              w_reg_we,
    output logic [REG_AW-1:0] w_reg_addr,
    output logic [DATA_W-1:0] w_pc8
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_cnt
`endif
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC8  = 2'd2;
    localparam logic [2:0] LD_LB    = 3'd1;
    localparam logic [2:0] LD_LBU   = 3'd2;
    localparam logic [2:0] LD_LH    = 3'd3;
    localparam logic [2:0] LD_LHU   = 3'd4;

    logic              valid_q;
    logic              reg_we_q;
    logic [REG_AW-1:0] reg_addr_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] pc8_q;
    logic [DATA_W-1:0] aux_q;
    logic [1:0]        sel_q;
    logic [2:0]        ld_type_q;

    // Each edge: flush beats stall beats capture. Flush clears only the control
    // fields; data fields simply hold because nothing downstream trusts them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
        end else if (!stall) begin
            valid_q    <= m_valid;
            reg_we_q   <= m_reg_we;
            reg_addr_q <= m_reg_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_q     <= '0;
            rdata_q   <= '0;
            pc8_q     <= '0;
            aux_q     <= '0;
            sel_q     <= '0;
            ld_type_q <= '0;
        end else if (!flush && !stall) begin
            alu_q     <= m_alu_out;
            rdata_q   <= m_rdata;
            pc8_q     <= m_pc8;
            aux_q     <= m_aux;
            sel_q     <= m_sel;
            ld_type_q <= m_ld_type;
        end
    end

    logic [1:0]        offset;
    logic [31:0]       word;
    logic [31:0]       byte_shift;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [DATA_W-1:0] load_ext;

    assign offset     = alu_q[1:0];
    assign word       = rdata_q[31:0];
    assign byte_shift = word >> {offset, 3'b000};
    assign byte_val   = byte_shift[7:0];
    // Unaligned halves read the aligned half that contains them.
    assign half_val   = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_ext = DATA_W'(word);
        case (ld_type_q)
            LD_LB:   load_ext = DATA_W'($signed(byte_val));
            LD_LBU:  load_ext = DATA_W'(byte_val);
            LD_LH:   load_ext = DATA_W'($signed(half_val));
            LD_LHU:  load_ext = DATA_W'(half_val);
            default: load_ext = DATA_W'(word);
        endcase
    end

    always_comb begin
        w_result = aux_q;
        case (sel_q)
            SEL_ALU:  w_result = alu_q;
            SEL_LOAD: w_result = load_ext;
            SEL_PC8:  w_result = pc8_q;
            default:  w_result = aux_q;
        endcase
    end

    assign w_valid    = valid_q;
    assign w_reg_addr = reg_addr_q;
    assign w_reg_we   = valid_q & reg_we_q & (reg_addr_q != '0);
    assign w_pc8      = pc8_q;

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_cnt <= '0;
        end else if (!flush && !stall && m_valid) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed plus randomized bench for wb_stage_reg against an arithmetic reference model.
// Covers the retirement counter when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage_reg;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          stall;
    logic          flush;
    logic          m_valid;
    logic [DW-1:0] m_alu_out;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_pc8;
    logic [DW-1:0] m_aux;
    logic [1:0]    m_sel;
    logic [2:0]    m_ld_type;
    logic          m_reg_we;
    logic [AW-1:0] m_reg_addr;
    logic          w_valid;
    logic [DW-1:0] w_result;
    logic          w_reg_we;
    logic [AW-1:0] w_reg_addr;
    logic [DW-1:0] w_pc8;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]   retire_cnt;
`endif

    wb_stage_reg #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_alu_out  (m_alu_out),
        .m_rdata    (m_rdata),
        .m_pc8      (m_pc8),
        .m_aux      (m_aux),
        .m_sel      (m_sel),
        .m_ld_type  (m_ld_type),
        .m_reg_we   (m_reg_we),
        .m_reg_addr (m_reg_addr),
        .w_valid    (w_valid),
        .w_result   (w_result),
        .w_reg_we   (w_reg_we),
        .w_reg_addr (w_reg_addr),
        .w_pc8      (w_pc8)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the instruction currently believed to sit in W.
    logic          e_valid;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_alu, e_rdata, e_pc8, e_aux;
    logic [1:0]    e_sel;
    logic [2:0]    e_ld;
    bit            e_known;
    logic [31:0]   e_cnt;

    function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [2:0] ld,
                                               input logic [31:0] alu, input logic [31:0] rdata,
                                               input logic [31:0] pc8, input logic [31:0] aux);
        logic [31:0] off;
        logic [31:0] b;
        logic [31:0] h;
        off = alu % 4;
        b   = (rdata / (32'd1 << (8 * off))) % 256;
        h   = (rdata / (32'd1 << (16 * (off / 2)))) % 65536;
        if (sel == 0) return alu;
        if (sel == 2) return pc8;
        if (sel == 3) return aux;
        case (ld)
            1: return (b >= 128) ? b - 256 : b;
            2: return b;
            3: return (h >= 32768) ? h - 65536 : h;
            4: return h;
            default: return rdata;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0; e_we = 1'b0; e_addr = '0;
        e_alu = '0; e_rdata = '0; e_pc8 = '0; e_aux = '0;
        e_sel = '0; e_ld = '0; e_known = 1'b1; e_cnt = '0;
    endtask

    task automatic model_edge();
        if (flush) begin
            e_valid = 1'b0; e_we = 1'b0; e_addr = '0; e_known = 1'b0;
        end else if (!stall) begin
            e_valid = m_valid; e_we = m_reg_we; e_addr = m_reg_addr;
            e_alu = m_alu_out; e_rdata = m_rdata; e_pc8 = m_pc8; e_aux = m_aux;
            e_sel = m_sel; e_ld = m_ld_type; e_known = 1'b1;
            if (m_valid) e_cnt = e_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(w_valid), 64'(e_valid));
        check({tag, ".we"}, 64'(w_reg_we), 64'(e_valid && e_we && (e_addr != 0)));
        check({tag, ".addr"}, 64'(w_reg_addr), 64'(e_addr));
        if (e_known) begin
            check({tag, ".result"}, 64'(w_result),
                  64'(ref_result(e_sel, e_ld, e_alu, e_rdata, e_pc8, e_aux)));
            check({tag, ".pc8"}, 64'(w_pc8), 64'(e_pc8));
        end
`ifdef WB_RETIRE_CNT_EN
        check({tag, ".cnt"}, 64'(retire_cnt), 64'(e_cnt));
`endif
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] addr,
                         input logic [1:0] sel, input logic [2:0] ld,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc8, input logic [31:0] aux);
        m_valid = v; m_reg_we = we; m_reg_addr = addr; m_sel = sel; m_ld_type = ld;
        m_alu_out = alu; m_rdata = rdata; m_pc8 = pc8; m_aux = aux;
    endtask

    task automatic drive_random();
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
              2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic all_zero(input string tag);
        check({tag, ".valid"}, 64'(w_valid), 64'(0));
        check({tag, ".result"}, 64'(w_result), 64'(0));
        check({tag, ".we"}, 64'(w_reg_we), 64'(0));
        check({tag, ".addr"}, 64'(w_reg_addr), 64'(0));
        check({tag, ".pc8"}, 64'(w_pc8), 64'(0));
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        all_zero("por");
        reset_n = 1'b1;

        // Async reset mid-cycle with nonzero inputs after a real capture.
        drive(1'b1, 1'b1, 5'd9, 2'd2, 3'd0, 32'h11, 32'h22, 32'h33, 32'h44);
        cycle("pre_rst");
        #3 reset_n = 1'b0;
        #1 model_reset();
        all_zero("async_rst");
        @(negedge clk) reset_n = 1'b1;

        drive(1'b1, 1'b1, 5'd8, 2'd1, 3'd0, 32'h0, 32'h12345678, 32'h0, 32'h0);
        cycle("lw");
        check("lw.lit", 64'(w_result), 64'h12345678);
        check("lw.we_lit", 64'(w_reg_we), 64'd1);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd1, 32'(i), 32'h80FF7F01, 32'h0, 32'h0);
            cycle($sformatf("lb%0d", i));
        end
        check("lb3.lit", 64'(w_result), 64'hFFFFFF80);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd1, 32'd2, 32'h80FF7F01, 32'h0, 32'h0);
        cycle("lb2");
        check("lb2.lit", 64'(w_result), 64'hFFFFFFFF);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd2, 32'd2, 32'h80FF7F01, 32'h0, 32'h0);
        cycle("lbu2");
        check("lbu2.lit", 64'(w_result), 64'h000000FF);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd3, 32'd2, 32'h80FF7F01, 32'h0, 32'h0);
        cycle("lh2");
        check("lh2.lit", 64'(w_result), 64'hFFFF80FF);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd4, 32'd3, 32'h80FF7F01, 32'h0, 32'h0);
        cycle("lhu3");
        check("lhu3.lit", 64'(w_result), 64'h000080FF);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd3, 32'd1, 32'h80FF7F01, 32'h0, 32'h0);
        cycle("lh1");
        check("lh1.lit", 64'(w_result), 64'h00007F01);

        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 1'b1, 5'd7, 2'(s), 3'd6, 32'hA, 32'hCAFE0001, 32'h00400008, 32'hBEEF);
            cycle($sformatf("sel%0d", s));
        end
        check("sel3.lit", 64'(w_result), 64'hBEEF);

        // Hold under stall, then flush wins over simultaneous stall.
        drive(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h5A5A, 32'h0, 32'h1000, 32'h0);
        cycle("cap_a");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            cycle($sformatf("stall%0d", i));
            check("stall.addr_lit", 64'(w_reg_addr), 64'd3);
            check("stall.res_lit", 64'(w_result), 64'h5A5A);
        end
        flush = 1'b1;
        cycle("flush_stall");
        check("flush.valid_lit", 64'(w_valid), 64'd0);
        check("flush.addr_lit", 64'(w_reg_addr), 64'd0);

        // Reset while stalled.
        flush = 1'b0;
        drive(1'b1, 1'b1, 5'd12, 2'd3, 3'd0, 32'h1, 32'h2, 32'h3, 32'h4);
        stall = 1'b0;
        cycle("cap_b");
        stall = 1'b1;
        cycle("stall_b");
        #2 reset_n = 1'b0;
        #1 model_reset();
        all_zero("rst_in_stall");
        @(negedge clk) begin reset_n = 1'b1; stall = 1'b0; end

        drive(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0);
        cycle("zero_reg");
        check("zero_reg.valid_lit", 64'(w_valid), 64'd1);
        check("zero_reg.we_lit", 64'(w_reg_we), 64'd0);
        drive(1'b0, 1'b1, 5'd5, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0);
        cycle("invalid");
        check("invalid.we_lit", 64'(w_reg_we), 64'd0);

        // Counter: valid, stall, valid, flush, valid.
        drive(1'b1, 1'b1, 5'd1, 2'd0, 3'd0, 32'h1, 32'h0, 32'h0, 32'h0);
        cycle("cnt_a");
        stall = 1'b1; cycle("cnt_stall"); stall = 1'b0;
        cycle("cnt_b");
        flush = 1'b1; cycle("cnt_flush"); flush = 1'b0;
        cycle("cnt_c");

        for (int i = 0; i < 400; i++) begin
            drive_random();
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            cycle($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage_reg.md
Name: wb_stage_reg

Overview:
- Parametrised successor to the single-mux writeback level of the pipelined MIPS core.
- Owns the M/W pipeline register: stall holds it, flush inserts a bubble.
- Performs load-data alignment and sign/zero extension for lb/lbu/lh/lhu/lw.
- Selects the register-file write value from four sources and produces the gated GRF write-enable and the W-stage forwarding value.

Parameters:
- DATA_W, 32, datapath width; must be >= 32. Load lanes come from bits [31:0]; extension fills up to DATA_W.
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- stall  input  1  hold W register contents
- flush  input  1  load bubble into W register
- m_valid  input  1  M-stage instruction valid
- m_alu_out  input  DATA_W  ALU result; also load address, bits [1:0] used as byte offset
- m_rdata  input  DATA_W  raw aligned memory word
- m_pc8  input  DATA_W  PC+8 for link instructions
- m_aux  input  DATA_W  HI/LO/CP0 read value
- m_sel  input  2  result select: 0 ALU, 1 load, 2 PC8, 3 AUX
- m_ld_type  input  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5-7 treated as lw
- m_reg_we  input  1  instruction writes GRF
- m_reg_addr  input  REG_AW  destination register
- w_valid  output  1  W register holds a valid instruction
- w_result  output  DATA_W  GRF write data / forwarding value
- w_reg_we  output  1  gated GRF write enable
- w_reg_addr  output  REG_AW  destination register
- w_pc8  output  DATA_W  PC+8 of W instruction (debug/trace)

Behaviour:
- Reset (reset_n low, asynchronous): all W register fields are 0, so w_valid=0, w_result=0, w_reg_we=0, w_reg_addr=0, w_pc8=0. Release is sampled at the next rising edge.
- At each rising edge, priority is flush > stall > capture:
  - flush=1: valid, reg_we and reg_addr cleared; data fields may hold any value. flush wins over a simultaneous stall.
  - stall=1, flush=0: all fields hold.
  - Otherwise: all m_* inputs are captured. The byte offset is m_alu_out[1:0].
- Latency: exactly one cycle from the M inputs to the W outputs. w_result is combinational from registered fields only; there is no combinational path from m_* to any output.
- Load extension, using registered offset off and word R = rdata[31:0]:
  - lb/lbu: byte R[8*off+7 : 8*off], sign- or zero-extended to DATA_W.
  - lh/lhu: half R[16*off[1]+15 : 16*off[1]]; off[0] is ignored, so an unaligned half reads the containing aligned half.
  - lw: R, zero-extended to DATA_W when DATA_W > 32.
- Result mux: sel 0 gives alu_out, 1 the extended load, 2 pc8, 3 aux.
- w_reg_we = w_valid & reg_we & (w_reg_addr != 0). Writes to $0 are never asserted.
- w_result is driven even when w_valid=0; consumers must gate on w_reg_we.
- reset_n asserted mid-stall or mid-flush: reset wins immediately and asynchronously.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt (input/output direction output, width 32), reset to 0.
  - Increments by 1 at every rising edge where flush=0, stall=0 and m_valid=1, i.e. a valid instruction is captured into W.
  - Wraps 0xFFFFFFFF to 0x00000000 with no flag.
  - Holds during stall and flush.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive reset_n=0 mid-cycle with all inputs nonzero -> all outputs 0 immediately. Release, then capture lw with rdata=0x12345678, sel=1, addr=8 -> next cycle w_result=0x12345678, w_reg_we=1, w_reg_addr=8.
- Byte/half extension: rdata=0x80FF7F01.
  - lb at offsets 0/1/2/3 -> 0x00000001 / 0x0000007F / 0xFFFFFFFF / 0xFFFFFF80.
  - lbu at offset 2 -> 0x000000FF.
  - lh at offset 2 -> 0xFFFF80FF.
  - lhu at offset 3 -> 0x000080FF.
  - lh at offset 1 -> 0x00007F01.
- Source select: alu=0xA, pc8=0x00400008, aux=0xBEEF -> sel 0/2/3 give 0xA / 0x00400008 / 0xBEEF. ld_type=6 with sel=1 behaves as lw.
- Stall/flush: capture instruction A (addr 3), then stall=1 for 3 cycles while inputs change -> outputs stay A. Then stall=1 and flush=1 together -> w_valid=0, w_reg_we=0, w_reg_addr=0.
- Zero register: m_reg_we=1, m_reg_addr=0, m_valid=1 -> w_valid=1, w_reg_we=0. m_valid=0 with addr 5 -> w_reg_we=0.
- WB_RETIRE_CNT_EN: preload the counter by issuing 0xFFFFFFFE captures (or force the counter), then 3 valid captures with one stall cycle and one flush between them -> counter reads 0xFFFFFFFF, then 0x00000000, then 0x00000001, unchanged during the stall and flush cycles.
